// File: rtl/option_pricing_pkg.sv
// option_pricing_pkg: shared widths, unit constant, FSM states and per-sample tags for the GBM path generator.
package option_pricing_pkg;
  localparam int PG_WIDTH = 12;
  localparam int PG_INT_LEN = 8;
  localparam int PG_FRAC = PG_WIDTH - PG_INT_LEN;
  localparam int PG_STEP_W = 9;
  localparam int PG_PATH_W = 16;
  localparam logic [PG_WIDTH-1:0] PG_ONE = PG_WIDTH'(1) << PG_FRAC;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef struct packed {
    logic first;
    logic last_step;
    logic last_path;
  } tag_t;
endpackage

// File: rtl/fp_mult_sat.sv
// fp_mult_sat: unsigned fixed-point multiply keeping the middle WIDTH bits; PATH_GEN_SAT_EN clamps overflow to all-ones.
module fp_mult_sat #(
  parameter int WIDTH = 12,
  parameter int INT_LEN = 8
) (
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] out,
  output logic             ovf
);
  localparam int FRAC = WIDTH - INT_LEN;
`ifdef PATH_GEN_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  logic [2*WIDTH-1:0] p;
  logic unused_lo;
  always_comb begin
    p = {{WIDTH{1'b0}}, in1} * {{WIDTH{1'b0}}, in2};
    ovf = |p[2*WIDTH-1:WIDTH+FRAC];
    out = (SAT && ovf) ? {WIDTH{1'b1}} : p[WIDTH+FRAC-1:FRAC];
    unused_lo = ^p[FRAC-1:0];
  end
endmodule

// File: rtl/path_gen_stream.sv
// path_gen_stream: streaming GBM path generator S[k+1] = S[k]*(q + w*eps[k]); PATH_GEN_SAT_EN selects saturating arithmetic.
module path_gen_stream
  import option_pricing_pkg::*;
#(
  parameter int WIDTH = PG_WIDTH,
  parameter int INT_LEN = PG_INT_LEN,
  parameter int STEP_W = PG_STEP_W,
  parameter int PATH_W = PG_PATH_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  cfg_s0,
  input  logic [WIDTH-1:0]  cfg_w,
  input  logic [WIDTH-1:0]  cfg_q,
  input  logic [STEP_W-1:0] cfg_n_steps,
  input  logic [PATH_W-1:0] cfg_n_paths,
  output logic              busy,
  output logic              done,
  input  logic              eps_valid,
  output logic              eps_ready,
  input  logic [WIDTH:0]    eps,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_price,
  output logic [STEP_W-1:0] out_step,
  output logic              out_last_step,
  output logic              out_last_path,
  output logic              ovf
);
`ifdef PATH_GEN_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  state_t state_q, state_d;
  logic [WIDTH-1:0] s0_q, w_q, q_q, prod1_q, fac2_q, s3_q;
  logic [WIDTH-1:0] prod_d, fac_d, price_d;
  logic [STEP_W-1:0] n_steps_q, in_step_q, step1_q, step2_q, step3_q;
  logic [PATH_W-1:0] n_paths_q, in_path_q;
  tag_t tag1_q, tag2_q, tag3_q;
  logic v1_q, v2_q, v3_q, sign1_q, ovf_q;
  logic m1_ovf, m2_ovf, add_ovf, adv, empty_cfg, owed, hs, last_hs, last_in, accept;
  logic [WIDTH:0] sum, diff;
  fp_mult_sat #(.WIDTH(WIDTH), .INT_LEN(INT_LEN)) u_mul_vol (
    .in1(w_q), .in2(eps[WIDTH-1:0]), .out(prod_d), .ovf(m1_ovf)
  );
  // Price stage restarts from S0 on the sample tagged first, so paths can be back-to-back.
  fp_mult_sat #(.WIDTH(WIDTH), .INT_LEN(INT_LEN)) u_mul_price (
    .in1(fac2_q), .in2(tag2_q.first ? s0_q : s3_q), .out(price_d), .ovf(m2_ovf)
  );
  always_comb begin
    adv = !v3_q || out_ready;
    empty_cfg = (n_steps_q == '0) || (n_paths_q == '0);
    owed = (state_q == RUN) && !empty_cfg && (in_path_q != n_paths_q);
    eps_ready = owed && adv;
    hs = eps_valid && eps_ready;
    last_in = in_step_q == n_steps_q - STEP_W'(1);
    last_hs = v3_q && out_ready && tag3_q.last_step && tag3_q.last_path;
    accept = (state_q == IDLE) && start;
    sum = {1'b0, q_q} + {1'b0, prod1_q};
    diff = {1'b0, q_q} - {1'b0, prod1_q};
    add_ovf = sign1_q ? diff[WIDTH] : sum[WIDTH];
    fac_d = (SAT && add_ovf) ? {WIDTH{!sign1_q}} : (sign1_q ? diff[WIDTH-1:0] : sum[WIDTH-1:0]);
    state_d = accept ? RUN : (state_q == RUN) ? ((empty_cfg || last_hs) ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      {s0_q, w_q, q_q, n_steps_q, n_paths_q, in_step_q, in_path_q} <= '0;
      {v1_q, prod1_q, sign1_q, tag1_q, step1_q} <= '0;
      {v2_q, fac2_q, tag2_q, step2_q} <= '0;
      {v3_q, s3_q, tag3_q, step3_q} <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        {s0_q, w_q, q_q, n_steps_q, n_paths_q} <= {cfg_s0, cfg_w, cfg_q, cfg_n_steps, cfg_n_paths};
        in_step_q <= '0;
        in_path_q <= '0;
        ovf_q <= 1'b0;
      end else begin
        if (hs) begin
          in_step_q <= last_in ? '0 : in_step_q + STEP_W'(1);
          if (last_in) in_path_q <= in_path_q + PATH_W'(1);
        end
        ovf_q <= ovf_q || (hs && m1_ovf) || (adv && v1_q && add_ovf) || (adv && v2_q && m2_ovf);
      end
      if (adv) begin
        v1_q <= hs;
        prod1_q <= prod_d;
        sign1_q <= eps[WIDTH];
        tag1_q <= '{first: in_step_q == '0, last_step: last_in, last_path: in_path_q == n_paths_q - PATH_W'(1)};
        step1_q <= in_step_q;
        v2_q <= v1_q;
        fac2_q <= fac_d;
        tag2_q <= tag1_q;
        step2_q <= step1_q;
        v3_q <= v2_q;
        if (v2_q) begin
          s3_q <= price_d;
          tag3_q <= tag2_q;
          step3_q <= step2_q;
        end
      end
    end
  end
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
  assign out_valid = v3_q;
  assign out_price = s3_q;
  assign out_step = step3_q;
  assign out_last_step = tag3_q.last_step;
  assign out_last_path = tag3_q.last_path;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_path_gen_stream.sv
// tb_path_gen_stream: randomized directed bench for path_gen_stream with an arithmetic GBM reference model.
module tb_path_gen_stream;
  import option_pricing_pkg::*;
`ifdef PATH_GEN_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, start, eps_valid, out_ready;
  logic [11:0] cfg_s0, cfg_w, cfg_q;
  logic [8:0] cfg_n_steps;
  logic [15:0] cfg_n_paths;
  logic [12:0] eps;
  logic busy, done, eps_ready, out_valid, out_last_step, out_last_path, ovf;
  logic [11:0] out_price;
  logic [8:0] out_step;
  int tests = 0, fails = 0;
  bit mo;
  logic [12:0] ev[$];
  int got[$];
  int ref_got[$];
  int first_price;
  always #5 clk = ~clk;
  path_gen_stream dut (
    .clk(clk), .rst(rst), .start(start), .cfg_s0(cfg_s0), .cfg_w(cfg_w), .cfg_q(cfg_q),
    .cfg_n_steps(cfg_n_steps), .cfg_n_paths(cfg_n_paths), .busy(busy), .done(done),
    .eps_valid(eps_valid), .eps_ready(eps_ready), .eps(eps), .out_valid(out_valid),
    .out_ready(out_ready), .out_price(out_price), .out_step(out_step),
    .out_last_step(out_last_step), .out_last_path(out_last_path), .ovf(ovf)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic int fmul(input int a, input int b);
    int p;
    p = a * b;
    if (p >= 65536) begin
      mo = 1'b1;
      return SAT ? 4095 : ((p >> 4) & 4095);
    end
    return (p >> 4) & 4095;
  endfunction
  function automatic int ffac(input int qv, input int pv, input bit neg);
    int r;
    r = neg ? qv - pv : qv + pv;
    if (r < 0 || r > 4095) begin
      mo = 1'b1;
      return SAT ? (r < 0 ? 0 : 4095) : (r & 4095);
    end
    return r;
  endfunction
  task automatic fill_eps(input int n, input logic [12:0] fixed, input bit rnd);
    ev.delete();
    for (int i = 0; i < n; i++)
      ev.push_back(rnd ? {1'($urandom_range(0, 1)), 12'($urandom_range(0, 20))} : fixed);
  endtask
  task automatic run_job(input logic [11:0] s0, input logic [11:0] w, input logic [11:0] q,
                         input int ns, input int np, input int pv, input int pr,
                         input bit glitch, input int abort_at);
    int ep[$];
    int et[$];
    int n, idx, cyc, dones, done_cyc, last_out, first_out, first_eps, er_seen, s, prod, fac;
    bit stalled, fin;
    logic [11:0] held;
    logic [12:0] e;
    n = ns * np;
    mo = 1'b0;
    got.delete();
    for (int p = 0; p < np; p++) begin
      s = int'(s0);
      for (int k = 0; k < ns; k++) begin
        e = ev[p * ns + k];
        prod = fmul(int'(w), int'(e[11:0]));
        fac = ffac(int'(q), prod, e[12]);
        s = fmul(fac, s);
        ep.push_back(s);
        et.push_back(int'({p == np - 1, k == ns - 1, 9'(k)}));
      end
    end
    idx = 0; dones = 0; done_cyc = -1; last_out = -1; first_out = -1; first_eps = -1;
    er_seen = 0; stalled = 1'b0; fin = 1'b0; held = '0;
    @(negedge clk);
    cfg_s0 = s0; cfg_w = w; cfg_q = q; cfg_n_steps = 9'(ns); cfg_n_paths = 16'(np);
    start = 1'b1; out_ready = 1'b1; eps_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    chk("busy_after_start", {31'd0, busy}, 1);
    while (!fin) begin
      if (abort_at > 0 && cyc == abort_at) begin
        rst = 1'b1; eps_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_outputs", {busy, done, eps_ready, out_valid, ovf, out_last_step, out_last_path, out_step, out_price}, 0);
        @(negedge clk);
        chk("no_done_after_rst", {31'd0, done}, 0);
        return;
      end
      if (done) begin dones++; done_cyc = cyc; end
      if (stalled) chk("hold_price", {out_valid, out_price}, {1'b1, held});
      eps_valid = $urandom_range(0, 99) < pv;
      eps = (idx < ev.size()) ? ev[idx] : 13'($urandom);
      out_ready = $urandom_range(0, 99) < pr;
      start = glitch && cyc == 5;
      if (start) cfg_s0 = 12'($urandom);
      #1;
      if (eps_ready) er_seen++;
      if (out_valid && out_ready) begin
        if (ep.size() == 0) chk("extra_beat", {31'd0, out_valid}, 0);
        else begin
          chk("price", out_price, ep[0]);
          chk("tags", {out_last_path, out_last_step, out_step}, et[0]);
          got.push_back(int'(out_price));
          void'(ep.pop_front());
          void'(et.pop_front());
        end
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
      end
      if (eps_valid && eps_ready) begin
        if (first_eps < 0) first_eps = cyc;
        idx++;
      end
      stalled = out_valid && !out_ready;
      held = out_price;
      fin = (dones > 0 && cyc == done_cyc + 1) || cyc > 3000;
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    eps_valid = 1'b0; out_ready = 1'b1;
    chk("within_budget", 32'(cyc <= 3002), 1);
    chk("beats_left", ep.size(), 0);
    chk("eps_used", idx, n);
    chk("done_count", dones, 1);
    chk("ovf", {31'd0, ovf}, {31'd0, mo});
    if (n == 0) begin
      chk("empty_done_cyc", done_cyc, 2);
      chk("empty_eps_ready", er_seen, 0);
    end else chk("done_after_last", done_cyc, last_out + 1);
    if (n > 0 && pv == 100 && pr == 100) begin
      chk("latency", first_out - first_eps, 3);
      chk("no_bubbles", last_out - first_out, n - 1);
    end
    chk("busy_idle", {31'd0, busy}, 0);
    if (got.size() > 0) first_price = got[0];
  endtask
  initial begin
    int mism;
    rst = 1'b1; start = 1'b0; eps_valid = 1'b0; out_ready = 1'b1; eps = '0;
    cfg_s0 = '0; cfg_w = '0; cfg_q = '0; cfg_n_steps = '0; cfg_n_paths = '0;
    repeat (3) @(negedge clk);
    chk("reset_state", {busy, done, eps_ready, out_valid, ovf, out_last_step, out_last_path, out_step, out_price}, 0);
    rst = 1'b0;
    fill_eps(1, 13'h0008, 1'b0);
    run_job(12'h640, 12'h008, PG_ONE, 1, 1, 100, 100, 1'b0, 0);
    chk("t1_price", first_price, 32'h7D0);
    fill_eps(1, 13'h1008, 1'b0);
    run_job(12'h640, 12'h008, PG_ONE, 1, 1, 100, 100, 1'b0, 0);
    chk("t2_neg_price", first_price, 32'h4B0);
    fill_eps(6, 13'h0008, 1'b0);
    run_job(12'h640, 12'h008, PG_ONE, 3, 2, 100, 100, 1'b0, 0);
    chk("t2_p0_s1", got[1], 32'h9C4);
    chk("t2_p0_s2", got[2], 32'hC35);
    chk("t2_p1_s0", got[3], 32'h7D0);
    fill_eps(1, 13'h0010, 1'b0);
    run_job(12'hC80, 12'h008, PG_ONE, 1, 1, 100, 100, 1'b0, 0);
    chk("t3_price", first_price, SAT ? 32'hFFF : 32'h2C0);
    chk("t3_ovf", {31'd0, ovf}, 1);
    fill_eps(1, 13'h1020, 1'b0);
    run_job(12'h640, 12'h010, PG_ONE, 1, 1, 100, 100, 1'b0, 0);
    chk("t4_price", first_price, SAT ? 32'h000 : 32'h9C0);
    chk("t4_ovf", {31'd0, ovf}, 1);
    fill_eps(64, 13'h0, 1'b1);
    run_job(12'h640, 12'h008, PG_ONE, 16, 4, 100, 100, 1'b0, 0);
    ref_got = got;
    run_job(12'h640, 12'h008, PG_ONE, 16, 4, 60, 50, 1'b1, 0);
    mism = 0;
    foreach (ref_got[i]) if (i >= got.size() || got[i] != ref_got[i]) mism++;
    chk("t5_gated_count", got.size(), 64);
    chk("t5_gated_same", mism, 0);
    fill_eps(64, 13'h0, 1'b1);
    run_job(12'h640, 12'h008, PG_ONE, 16, 4, 80, 80, 1'b0, 25);
    run_job(12'h640, 12'h008, PG_ONE, 16, 0, 100, 100, 1'b0, 0);
    run_job(12'h640, 12'h008, PG_ONE, 0, 3, 100, 100, 1'b0, 0);
    fill_eps(4, 13'h0008, 1'b0);
    run_job(12'h640, 12'h008, PG_ONE, 2, 2, 100, 100, 1'b0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
